// File: rtl/falu_arbiter.sv
// rtl/falu_arbiter.sv - round-robin arbiter sharing one multicycle FP ALU
//
// Purpose: grants NREQ requesters round-robin access to a single
// combinational floating-point ALU. It registers the granted operands onto
// the ALU inputs and holds them for LAT cycles, so the ALU may be timed as a
// LAT-cycle multicycle path. It then captures the result and returns it to
// the owning requester through a valid/ready handshake.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   req_valid/req_ready per-requester request handshake (ready is one-hot)
//   req_opf/req_b/req_c packed per-requester op code and operands
//   rsp_valid/rsp_ready per-requester result handshake (valid is one-hot)
//   rsp_data            captured ALU result
//   busy                high whenever the arbiter is not idle
//   falu_opf/b/c        registered op code and operands driven to the ALU
//   falu_a              ALU result
module falu_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 2
) (
  input  logic [0:0]         clk,
  input  logic [0:0]         rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [2*NREQ-1:0]  req_opf,
  input  logic [32*NREQ-1:0] req_b,
  input  logic [32*NREQ-1:0] req_c,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [31:0]        rsp_data,
  output logic [0:0]         busy,
  output logic [1:0]         falu_opf,
  output logic [31:0]        falu_b,
  output logic [31:0]        falu_c,
  input  logic [31:0]        falu_a
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic [1:0]    opf_q, opf_d;
  logic [31:0]   b_q, b_d;
  logic [31:0]   c_q, c_d;
  logic [31:0]   data_q, data_d;

  logic          grant_found;
  logic [IW-1:0] grant_idx;

  // Round-robin search starting just after the previous grant; the first
  // hit wins, so the previous owner is always searched last.
  always_comb begin
    int            pos;
    logic [IW-1:0] pos_idx;
    grant_found = 1'b0;
    grant_idx   = last_q;
    pos         = 0;
    pos_idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      pos     = (int'(last_q) + k) % NREQ;
      pos_idx = pos[IW-1:0];
      if (!grant_found && req_valid[pos_idx]) begin
        grant_found = 1'b1;
        grant_idx   = pos_idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    opf_d     = opf_q;
    b_d       = b_q;
    c_d       = c_q;
    data_d    = data_q;
    req_ready = '0;
    rsp_valid = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          opf_d   = req_opf[2*grant_idx +: 2];
          b_d     = req_b[32*grant_idx +: 32];
          c_d     = req_c[32*grant_idx +: 32];
          owner_d = grant_idx;
          last_d  = grant_idx;
          cnt_d   = CW'(LAT);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q - 1'b1;
        // Last cycle of the hold window: ALU output has had LAT cycles.
        if (cnt_q == CW'(1)) begin
          data_d  = falu_a;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      owner_q <= '0;
      last_q  <= IW'(NREQ - 1);
      opf_q   <= '0;
      b_q     <= '0;
      c_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      opf_q   <= opf_d;
      b_q     <= b_d;
      c_q     <= c_d;
      data_q  <= data_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign rsp_data = data_q;
  assign falu_opf = opf_q;
  assign falu_b   = b_q;
  assign falu_c   = c_q;

endmodule

// File: tb/tb_falu_arbiter.sv
// tb/tb_falu_arbiter.sv - self-checking bench for falu_arbiter (LAT=2 and LAT=1 builds)
module tb_falu_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // NREQ=4, LAT=2 instance
  logic [3:0]   a_req_valid = '0;
  logic [3:0]   a_req_ready;
  logic [7:0]   a_req_opf = '0;
  logic [127:0] a_req_b = '0;
  logic [127:0] a_req_c = '0;
  logic [3:0]   a_rsp_valid;
  logic [3:0]   a_rsp_ready = '1;
  logic [31:0]  a_rsp_data;
  logic         a_busy;
  logic [1:0]   a_falu_opf;
  logic [31:0]  a_falu_b, a_falu_c, a_falu_a;

  // NREQ=2, LAT=1 instance
  logic [1:0]  l_req_valid = '0;
  logic [1:0]  l_req_ready;
  logic [3:0]  l_req_opf = '0;
  logic [63:0] l_req_b = '0;
  logic [63:0] l_req_c = '0;
  logic [1:0]  l_rsp_valid;
  logic [1:0]  l_rsp_ready = '1;
  logic [31:0] l_rsp_data;
  logic        l_busy;
  logic [1:0]  l_falu_opf;
  logic [31:0] l_falu_b, l_falu_c, l_falu_a;

  falu_arbiter #(.NREQ(4), .LAT(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_opf(a_req_opf), .req_b(a_req_b), .req_c(a_req_c),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
    .busy(a_busy), .falu_opf(a_falu_opf), .falu_b(a_falu_b), .falu_c(a_falu_c),
    .falu_a(a_falu_a)
  );

  falu_arbiter #(.NREQ(2), .LAT(1)) dut_lat1 (
    .clk(clk), .rst(rst),
    .req_valid(l_req_valid), .req_ready(l_req_ready),
    .req_opf(l_req_opf), .req_b(l_req_b), .req_c(l_req_c),
    .rsp_valid(l_rsp_valid), .rsp_ready(l_rsp_ready), .rsp_data(l_rsp_data),
    .busy(l_busy), .falu_opf(l_falu_opf), .falu_b(l_falu_b), .falu_c(l_falu_c),
    .falu_a(l_falu_a)
  );

  // Table ALU for the operand combinations used below.
  function automatic logic [31:0] alu_f(logic [1:0] op, logic [31:0] b, logic [31:0] c);
    case ({op, b, c})
      {2'd0, 32'h3F800000, 32'h40000000}: return 32'h40400000; // 1+2
      {2'd1, 32'h40400000, 32'h3F800000}: return 32'h40000000; // 3-1
      {2'd2, 32'h40000000, 32'h3F800000}: return 32'h40000000; // 2*1
      {2'd2, 32'h40000000, 32'h40000000}: return 32'h40800000; // 2*2
      {2'd2, 32'h40000000, 32'h40400000}: return 32'h40C00000; // 2*3
      {2'd2, 32'h40000000, 32'h40800000}: return 32'h41000000; // 2*4
      {2'd3, 32'h40C00000, 32'h40000000}: return 32'h40400000; // 6/2
      default: return 32'h7FBADBAD;
    endcase
  endfunction

  // Multicycle ALU model: output is garbage until inputs have been stable
  // for LAT cycles, so an early sample returns a wrong value.
  int          a_stable = 0;
  int          l_stable = 0;
  logic [65:0] a_prev = '0;
  logic [65:0] l_prev = '0;

  always @(posedge clk) begin
    #1;
    if ({a_falu_opf, a_falu_b, a_falu_c} !== a_prev) a_stable = 1;
    else if (a_stable < 1000) a_stable = a_stable + 1;
    a_prev = {a_falu_opf, a_falu_b, a_falu_c};
    if ({l_falu_opf, l_falu_b, l_falu_c} !== l_prev) l_stable = 1;
    else if (l_stable < 1000) l_stable = l_stable + 1;
    l_prev = {l_falu_opf, l_falu_b, l_falu_c};
  end

  assign a_falu_a = (a_stable >= 2) ? alu_f(a_falu_opf, a_falu_b, a_falu_c) : 32'h7FBADBAD;
  assign l_falu_a = (l_stable >= 1) ? alu_f(l_falu_opf, l_falu_b, l_falu_c) : 32'h7FBADBAD;

  typedef struct {
    int          owner;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [31:0] C_TAB [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  localparam logic [31:0] R_TAB [4] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set_req(int i, logic [1:0] op, logic [31:0] b, logic [31:0] c);
    a_req_opf[2*i +: 2] = op;
    a_req_b[32*i +: 32] = b;
    a_req_c[32*i +: 32] = c;
    a_req_valid[i]      = 1'b1;
  endtask

  task automatic accept(int idx, logic [31:0] data, string tag);
    int   guard;
    exp_t e;
    guard = 0;
    while (a_req_ready == '0 && guard < 20) begin
      tick();
      guard++;
    end
    chk({tag, "_grant"}, 32'(a_req_ready), 32'(1) << idx);
    e.owner = idx;
    e.data  = data;
    sb.push_back(e);
  endtask

  task automatic respond(string tag);
    int   guard;
    exp_t e;
    guard = 0;
    while (a_rsp_valid == '0 && guard < 20) begin
      tick();
      guard++;
    end
    if (sb.size() == 0) begin
      chk({tag, "_unexpected_rsp"}, 32'(a_rsp_valid), 32'h0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rsp_valid"}, 32'(a_rsp_valid), 32'(1) << e.owner);
      chk({tag, "_rsp_data"}, a_rsp_data, e.data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_req_ready", 32'(a_req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(a_rsp_valid), 32'h0);
    chk("rst_rsp_data", a_rsp_data, 32'h0);
    chk("rst_busy", 32'(a_busy), 32'h0);
    chk("rst_falu_opf", 32'(a_falu_opf), 32'h0);
    chk("rst_falu_b", a_falu_b, 32'h0);
    chk("rst_falu_c", a_falu_c, 32'h0);
    rst = 1'b0;
    tick();

    // Single ADD: accept at T, rsp_valid at T+3
    set_req(0, 2'd0, 32'h3F800000, 32'h40000000);
    #1;
    accept(0, 32'h40400000, "add");
    chk("add_busy_T", 32'(a_busy), 32'h0);
    tick();
    a_req_valid = '0;
    chk("add_busy_T1", 32'(a_busy), 32'h1);
    chk("add_rsp_T1", 32'(a_rsp_valid), 32'h0);
    chk("add_falu_b", a_falu_b, 32'h3F800000);
    chk("add_falu_c", a_falu_c, 32'h40000000);
    chk("add_falu_opf", 32'(a_falu_opf), 32'h0);
    tick();
    chk("add_busy_T2", 32'(a_busy), 32'h1);
    chk("add_rsp_T2", 32'(a_rsp_valid), 32'h0);
    tick();
    chk("add_rsp_T3", 32'(a_rsp_valid), 32'h1);
    chk("add_busy_T3", 32'(a_busy), 32'h1);
    respond("add");
    tick();
    chk("add_busy_T4", 32'(a_busy), 32'h0);
    chk("add_rsp_T4", 32'(a_rsp_valid), 32'h0);

    // Round-robin with all four requesting after a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 2'd2, 32'h40000000, C_TAB[i]);
    #1;
    for (int n = 0; n < 5; n++) begin
      accept(n % 4, R_TAB[n % 4], "rr");
      tick();
      if (n == 4) a_req_valid = '0;
      chk("rr_ready_in_exec", 32'(a_req_ready), 32'h0);
      respond("rr");
      tick();
    end
    chk("rr_idle_busy", 32'(a_busy), 32'h0);

    // Fairness: last grant was 0, so 4'b0101 goes 2, then 0, then 2
    set_req(0, 2'd2, 32'h40000000, 32'h40400000);
    set_req(2, 2'd3, 32'h40C00000, 32'h40000000);
    #1;
    accept(2, 32'h40400000, "fair_a");
    tick();
    respond("fair_a");
    tick();
    accept(0, 32'h40C00000, "fair_b");
    tick();
    respond("fair_b");
    tick();
    accept(2, 32'h40400000, "fair_c");
    tick();
    a_req_valid = '0;
    respond("fair_c");
    tick();

    // Backpressure on requester 1 while requester 3 waits
    a_rsp_ready = 4'b1101;
    set_req(1, 2'd0, 32'h3F800000, 32'h40000000);
    #1;
    accept(1, 32'h40400000, "bp");
    tick();
    a_req_valid = '0;
    set_req(3, 2'd1, 32'h40400000, 32'h3F800000);
    respond("bp");
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_hold_valid", 32'(a_rsp_valid), 32'h2);
      chk("bp_hold_data", a_rsp_data, 32'h40400000);
      chk("bp_hold_ready", 32'(a_req_ready), 32'h0);
    end
    a_rsp_ready[1] = 1'b1;
    tick();
    chk("bp_next_grant", 32'(a_req_ready), 32'h8);
    accept(3, 32'h40000000, "bp_next");
    tick();
    a_req_valid = '0;
    respond("bp_next");
    tick();

    // Reset in the middle of EXEC
    set_req(0, 2'd0, 32'h3F800000, 32'h40000000);
    #1;
    accept(0, 32'h40400000, "rstx");
    tick();
    a_req_valid = '0;
    rst = 1'b1;
    tick();
    sb.delete();
    chk("rstx_busy", 32'(a_busy), 32'h0);
    chk("rstx_rsp_valid", 32'(a_rsp_valid), 32'h0);
    chk("rstx_rsp_data", a_rsp_data, 32'h0);
    chk("rstx_falu_b", a_falu_b, 32'h0);
    chk("rstx_falu_opf", 32'(a_falu_opf), 32'h0);
    rst = 1'b0;
    set_req(0, 2'd2, 32'h40000000, 32'h40800000);
    set_req(1, 2'd0, 32'h3F800000, 32'h40000000);
    #1;
    accept(0, 32'h41000000, "rstx_prio");
    tick();
    a_req_valid[0] = 1'b0;
    respond("rstx_prio");
    tick();
    accept(1, 32'h40400000, "rstx_next");
    tick();
    a_req_valid = '0;
    respond("rstx_next");
    tick();

    // LAT=1 build: SUB, result at T+2, operands held through IDLE
    chk("l_falu_b_rst", l_falu_b, 32'h0);
    l_req_opf[1:0]  = 2'd1;
    l_req_b[31:0]   = 32'h40400000;
    l_req_c[31:0]   = 32'h3F800000;
    l_req_valid[0]  = 1'b1;
    #1;
    chk("l_grant", 32'(l_req_ready), 32'h1);
    tick();
    l_req_valid = '0;
    chk("l_busy_T1", 32'(l_busy), 32'h1);
    chk("l_rsp_T1", 32'(l_rsp_valid), 32'h0);
    tick();
    chk("l_rsp_T2", 32'(l_rsp_valid), 32'h1);
    chk("l_data_T2", l_rsp_data, 32'h40000000);
    tick();
    chk("l_busy_T3", 32'(l_busy), 32'h0);
    for (int k = 0; k < 3; k++) begin
      chk("l_hold_b", l_falu_b, 32'h40400000);
      chk("l_hold_c", l_falu_c, 32'h3F800000);
      chk("l_hold_opf", 32'(l_falu_opf), 32'h1);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
